// File: rtl/imem_access_arbiter.sv
// Arbitrates the shared instruction memory between the CPU fetch port and the loader/debug port.
// Optional starvation guard for the loader is enabled by defining IMEM_ARB_STARVE_EN.
module imem_access_arbiter #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
`ifdef IMEM_ARB_STARVE_EN
    ,
    parameter int unsigned STARVE_MAX = 4
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_valid,
    output logic [DW-1:0] l_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;

`ifdef IMEM_ARB_STARVE_EN
    localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] starve_cnt;
    logic           starve_hit;

    assign starve_hit = (starve_cnt == SCW'(STARVE_MAX));

    // Consecutive RUN-state loader denials; saturates so the forced grant always fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if ((state == ST_RUN) && l_req && !l_gnt) begin
            if (!starve_hit) begin
                starve_cnt <= starve_cnt + SCW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end
`endif

    // Next state and grant decision.
    always_comb begin
        state_nxt = state;
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        case (state)
            ST_RUN: begin
                if (l_lock) begin
                    l_gnt     = l_req;
                    state_nxt = ST_LOCK;
                end else begin
`ifdef IMEM_ARB_STARVE_EN
                    if (l_req && (!f_req || starve_hit)) begin
                        l_gnt = 1'b1;
                    end else begin
                        f_gnt = f_req;
                    end
`else
                    f_gnt = f_req;
                    l_gnt = l_req & ~f_req;
`endif
                end
            end
            ST_LOCK: begin
                l_gnt = l_req;
                if (!l_lock) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Memory port follows the winner; idle cycles park the address at zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    // Unlocked loader writes degrade to reads.
    assign mem_we = l_gnt & l_we & l_lock;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            cpu_stall <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_stall <= (state_nxt == ST_LOCK);
        end
    end

    // Read data is captured in the grant cycle; valid pulses for the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_valid <= 1'b0;
            f_rdata <= '0;
            l_valid <= 1'b0;
            l_rdata <= '0;
        end else begin
            f_valid <= f_gnt;
            l_valid <= l_gnt;
            if (f_gnt) begin
                f_rdata <= mem_rdata;
            end
            if (l_gnt) begin
                l_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Self-checking bench for imem_access_arbiter: directed vector table, reset and starvation
// sequences, then random traffic against a behavioural model with a shadow memory.
module tb_imem_access_arbiter;

    localparam int STARVE_MAX = 4;
`ifdef IMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        f_req;
    logic [5:0]  f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic        l_we;
    logic        l_lock;
    logic [5:0]  l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_valid;
    logic [31:0] l_rdata;
    logic        cpu_stall;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [64];
    assign mem_rdata = ram[mem_addr];

    imem_access_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_valid   (f_valid),
        .f_rdata   (f_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_lock    (l_lock),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_valid   (l_valid),
        .l_rdata   (l_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] sh [64];
    bit          m_lock;
    int          m_denials;
    bit          m_fv, m_lv, m_stall;
    logic [31:0] m_fd, m_ld;
    bit          e_f, e_l, e_we;
    bit          s_we;
    logic [5:0]  s_addr;
    logic [31:0] s_wd;

    typedef struct {
        logic        fr;
        logic [5:0]  fa;
        logic        lr, lw, lk;
        logic [5:0]  la;
        logic [31:0] wd;
        logic        efg, elg, ewe;
        logic        efv, elv, est;
        logic        cfd;
        logic [31:0] efd;
        logic        cld;
        logic [31:0] eld;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lock    = 1'b0;
        m_denials = 0;
        m_fv      = 1'b0;
        m_lv      = 1'b0;
        m_stall   = 1'b0;
        m_fd      = '0;
        m_ld      = '0;
    endtask

    // Predict this cycle's grants, wait to mid-cycle, compare everything visible.
    task automatic eval_cycle(input string tag);
        logic [5:0] ea;
        if (m_lock || l_lock) begin
            e_f = 1'b0;
            e_l = l_req;
        end else begin
            e_l = l_req && (!f_req || (STARVE && (m_denials >= STARVE_MAX)));
            e_f = f_req && !e_l;
        end
        e_we = e_l && l_we && l_lock;
        ea = e_f ? f_addr : (e_l ? l_addr : 6'd0);
        @(negedge clk);
        chk({tag, ".f_gnt"},     32'(f_gnt),     32'(e_f));
        chk({tag, ".l_gnt"},     32'(l_gnt),     32'(e_l));
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'(ea));
        chk({tag, ".mem_we"},    32'(mem_we),    32'(e_we));
        if (e_we) chk({tag, ".mem_wdata"}, mem_wdata, l_wdata);
        chk({tag, ".f_valid"},   32'(f_valid),   32'(m_fv));
        chk({tag, ".f_rdata"},   f_rdata,        m_fd);
        chk({tag, ".l_valid"},   32'(l_valid),   32'(m_lv));
        chk({tag, ".l_rdata"},   l_rdata,        m_ld);
        chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(m_stall));
        s_we   = mem_we;
        s_addr = mem_addr;
        s_wd   = mem_wdata;
    endtask

    // Clock edge: memory write, then model bookkeeping from the same inputs.
    task automatic advance();
        @(posedge clk);
        #1;
        if (s_we) ram[s_addr] = s_wd;
        m_fv = e_f;
        m_lv = e_l;
        if (e_f) m_fd = sh[f_addr];
        if (e_l) m_ld = sh[l_addr];
        if (e_we) sh[l_addr] = l_wdata;
        if (l_req && !e_l) m_denials = (m_denials < STARVE_MAX) ? m_denials + 1 : m_denials;
        else m_denials = 0;
        m_lock  = l_lock;
        m_stall = l_lock;
    endtask

    task automatic drive(input logic fr, input logic [5:0] fa, input logic lr, input logic lw,
                         input logic lk, input logic [5:0] la, input logic [31:0] wd);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = wd;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
        end
        ram[0] = 32'h20080005;
        ram[1] = 32'h20090006;
        ram[2] = 32'h012a4020;
        ram[3] = 32'h3c0b1234;
        for (int i = 0; i < 64; i++) begin
            sh[i] = ram[i];
        end

        //          fr    fa     lr    lw    lk    la     wd            efg   elg   ewe   efv   elv   est   cfd   efd           cld   eld
        tbl[0]  = '{1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1]  = '{1'b1, 6'd1,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20080005, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 6'd2,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20090006, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h012a4020, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 6'd3,  32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        tbl[5]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3c0b1234};
        tbl[6]  = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b1, 6'd10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        tbl[7]  = '{1'b1, 6'd10, 1'b1, 1'b0, 1'b1, 6'd10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
        tbl[8]  = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 6'd10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[9]  = '{1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 6'd10, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[10] = '{1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        tbl[11] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};

        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("reset.f_valid",   32'(f_valid),   32'h0);
        chk("reset.l_valid",   32'(l_valid),   32'h0);
        chk("reset.cpu_stall", 32'(cpu_stall), 32'h0);
        chk("reset.f_rdata",   f_rdata,        32'h0);
        chk("reset.l_rdata",   l_rdata,        32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].fr, tbl[i].fa, tbl[i].lr, tbl[i].lw, tbl[i].lk, tbl[i].la, tbl[i].wd);
            eval_cycle(t);
            chk({t, ".tbl_f_gnt"},     32'(f_gnt),     32'(tbl[i].efg));
            chk({t, ".tbl_l_gnt"},     32'(l_gnt),     32'(tbl[i].elg));
            chk({t, ".tbl_mem_we"},    32'(mem_we),    32'(tbl[i].ewe));
            chk({t, ".tbl_f_valid"},   32'(f_valid),   32'(tbl[i].efv));
            chk({t, ".tbl_l_valid"},   32'(l_valid),   32'(tbl[i].elv));
            chk({t, ".tbl_cpu_stall"}, 32'(cpu_stall), 32'(tbl[i].est));
            if (tbl[i].cfd) chk({t, ".tbl_f_rdata"}, f_rdata, tbl[i].efd);
            if (tbl[i].cld) chk({t, ".tbl_l_rdata"}, l_rdata, tbl[i].eld);
            advance();
        end
        chk("ram3_unlocked_write_ignored", ram[3], 32'h3c0b1234);

        // Sustained contention: loader only wins on the starvation slot
        for (int i = 0; i < 10; i++) begin
            logic exp_l;
            exp_l = STARVE && ((i % 5) == 4);
            drive(1'b1, 6'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b0, 6'($urandom_range(0, 63)), 32'h0);
            eval_cycle($sformatf("starve%0d", i));
            chk($sformatf("starve%0d.pattern_l", i), 32'(l_gnt), 32'(exp_l));
            chk($sformatf("starve%0d.pattern_f", i), 32'(f_gnt), 32'(!exp_l));
            advance();
        end
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        eval_cycle("starve_clr");
        advance();

        // Reset asserted while a fetch is outstanding
        drive(1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        eval_cycle("rst_pre");
        advance();
        f_addr = 6'd5;
        eval_cycle("rst_mid");
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid.async_f_valid", 32'(f_valid), 32'h0);
        chk("rst_mid.async_f_rdata", f_rdata, 32'h0);
        chk("rst_mid.async_cpu_stall", 32'(cpu_stall), 32'h0);
        f_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.no_resp", 32'(f_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Reset asserted while the loader holds the lock
        drive(1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 6'd7, 32'h0);
        eval_cycle("rst_lk_pre");
        advance();
        eval_cycle("rst_lk");
        #2 reset_n = 1'b0;
        #1;
        chk("rst_lk.async_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("rst_lk.async_l_valid", 32'(l_valid), 32'h0);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        drive(1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 6'd9, 32'h0);
        eval_cycle("rst_run");
        chk("rst_run.fetch_wins", 32'(f_gnt), 32'h1);
        advance();

        // Random traffic
        l_lock = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) l_lock = ~l_lock;
            f_req   = ($urandom_range(0, 9) < 7);
            f_addr  = 6'($urandom_range(0, 63));
            l_req   = ($urandom_range(0, 1) == 1);
            l_we    = ($urandom_range(0, 1) == 1);
            l_addr  = 6'($urandom_range(0, 63));
            l_wdata = $urandom;
            eval_cycle($sformatf("rnd%0d", i));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
